// File: rtl/present_core_pixel_scanner_if.sv
// Pixel coordinate stream: valid/ready handshake that carries one (x,y) beat
// per pixel, together with end-of-line and end-of-frame markers.
interface present_core_pixel_scanner_if #(
  parameter int DIM_W = 16
);
  logic             out_valid;
  logic             out_ready;
  logic [DIM_W-1:0] out_x;
  logic [DIM_W-1:0] out_y;
  logic             out_eol;
  logic             out_eof;

  // The scanner produces beats.
  modport master (
    output out_valid, out_x, out_y, out_eol, out_eof,
    input  out_ready
  );

  // The downstream pixel engine consumes beats.
  modport slave (
    input  out_valid, out_x, out_y, out_eol, out_eof,
    output out_ready
  );
endinterface

// File: rtl/present_core_pixel_scanner.sv
// Raster coordinate generator. A start pulse latches the frame size and the
// block then emits one (x,y) beat per pixel, row-major, on a valid/ready
// stream, followed by a one-cycle done pulse.
// Optional feature macro: PRESENT_CORE_SCAN_FRAME_CNT_EN -- when defined,
// frame_count counts completed frames; otherwise it is tied to zero.
module present_core_pixel_scanner #(
  parameter int DIM_W = 16
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [31:0]                   cfg_width,
  input  logic [31:0]                   cfg_height,
  input  logic                          start,
  input  logic                          abort,
  present_core_pixel_scanner_if.master  pix,
  output logic                          busy,
  output logic                          done,
  output logic [31:0]                   frame_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [DIM_W-1:0] w_q, w_d;
  logic [DIM_W-1:0] h_q, h_d;
  logic [DIM_W-1:0] x_q, x_d;
  logic [DIM_W-1:0] y_q, y_d;

  // Only the low DIM_W bits of the size words are meaningful.
  logic [DIM_W-1:0] cfg_w;
  logic [DIM_W-1:0] cfg_h;
  logic             unused_cfg_hi;
  assign cfg_w         = cfg_width[DIM_W-1:0];
  assign cfg_h         = cfg_height[DIM_W-1:0];
  assign unused_cfg_hi = ^{cfg_width[31:DIM_W], cfg_height[31:DIM_W]};

  // Compare x+1 / y+1 one bit wider so a W or H of 0 never looks like a
  // last column/row, and the maximum size 2^DIM_W-1 does not overflow.
  logic [DIM_W:0] x_inc;
  logic [DIM_W:0] y_inc;
  logic           last_col;
  logic           last_row;
  logic           in_scan;
  assign x_inc    = {1'b0, x_q} + {{DIM_W{1'b0}}, 1'b1};
  assign y_inc    = {1'b0, y_q} + {{DIM_W{1'b0}}, 1'b1};
  assign last_col = (x_inc == {1'b0, w_q});
  assign last_row = (y_inc == {1'b0, h_q});
  assign in_scan  = (state_q == SCAN);

  // Stream and status outputs decode straight from registered state, so they
  // hold steady while the downstream stalls.
  assign pix.out_valid = in_scan;
  assign pix.out_x     = x_q;
  assign pix.out_y     = y_q;
  assign pix.out_eol   = in_scan && last_col;
  assign pix.out_eof   = in_scan && last_col && last_row;
  assign busy          = in_scan;
  assign done          = (state_q == DONE);

  // Next-state logic: abort wins over everything, start is only seen in IDLE.
  always_comb begin
    state_d = state_q;
    w_d     = w_q;
    h_d     = h_q;
    x_d     = x_q;
    y_d     = y_q;
    if (abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            w_d     = cfg_w;
            h_d     = cfg_h;
            x_d     = '0;
            y_d     = '0;
            state_d = ((cfg_w == '0) || (cfg_h == '0)) ? DONE : SCAN;
          end
        end
        SCAN: begin
          if (pix.out_ready) begin
            if (last_col) begin
              if (last_row) begin
                state_d = DONE;
              end else begin
                x_d = '0;
                y_d = y_inc[DIM_W-1:0];
              end
            end else begin
              x_d = x_inc[DIM_W-1:0];
            end
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // State, frame size and coordinate registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      w_q     <= '0;
      h_q     <= '0;
      x_q     <= '0;
      y_q     <= '0;
    end else begin
      state_q <= state_d;
      w_q     <= w_d;
      h_q     <= h_d;
      x_q     <= x_d;
      y_q     <= y_d;
    end
  end

`ifdef PRESENT_CORE_SCAN_FRAME_CNT_EN
  logic [31:0] frame_cnt_q, frame_cnt_d;

  // One count per done pulse; wraps naturally at 32 bits.
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (state_q == DONE) begin
      frame_cnt_d = frame_cnt_q + 32'd1;
    end
  end

  // Completed-frame counter register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_cnt_q <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign frame_count = frame_cnt_q;
`else
  assign frame_count = 32'h0;
`endif

endmodule

// File: tb/tb_present_core_pixel_scanner.sv
// Scoreboard bench for the raster scanner: stimulus pushes the expected
// beats and done pulses computed from frame dimensions; a negedge monitor
// pops and compares whenever the DUT transfers a beat or pulses done.
module tb_present_core_pixel_scanner;
  localparam int DIM_W = 16;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] cfg_width = '0;
  logic [31:0] cfg_height = '0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        busy;
  logic        done;
  logic [31:0] frame_count;

  present_core_pixel_scanner_if #(.DIM_W(DIM_W)) bus ();

  present_core_pixel_scanner #(.DIM_W(DIM_W)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .cfg_width   (cfg_width),
    .cfg_height  (cfg_height),
    .start       (start),
    .abort       (abort),
    .pix         (bus),
    .busy        (busy),
    .done        (done),
    .frame_count (frame_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int x;
    int y;
    bit eol;
    bit eof;
    int cyc;   // expected cycle of transfer, -1 when not timed
  } beat_t;

  typedef struct {
    int cnt;   // frame_count expected while done is high
    int cyc;   // expected cycle of done, -1 when not timed
  } done_t;

  beat_t beat_q[$];
  done_t done_q[$];

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int beats_seen = 0;
  int model_frames = 0;
  bit rand_ready = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Downstream ready: held high, or random while rand_ready is set.
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor / scoreboard.
  bit          prev_stall = 1'b0;
  logic [15:0] prev_x, prev_y;
  logic        prev_eol, prev_eof;

  always @(negedge clk) begin
    if (!reset_n) begin
      beat_q.delete();
      done_q.delete();
      prev_stall = 1'b0;
    end else begin
      if (busy !== bus.out_valid) chk("busy_vs_valid", busy, bus.out_valid);
      if (prev_stall && bus.out_valid) begin
        chk("stall_x", bus.out_x, prev_x);
        chk("stall_y", bus.out_y, prev_y);
        chk("stall_eol", bus.out_eol, prev_eol);
        chk("stall_eof", bus.out_eof, prev_eof);
      end
      if (bus.out_valid && bus.out_ready) begin
        beats_seen++;
        if (beat_q.size() == 0) begin
          chk("unexpected_beat_y", bus.out_y, -1);
        end else begin
          beat_t b;
          b = beat_q.pop_front();
          chk("beat_x", bus.out_x, b.x);
          chk("beat_y", bus.out_y, b.y);
          chk("beat_eol", bus.out_eol, b.eol);
          chk("beat_eof", bus.out_eof, b.eof);
          if (b.cyc >= 0) chk("beat_cycle", cyc, b.cyc);
        end
      end
      if (done) begin
        if (done_q.size() == 0) begin
          chk("unexpected_done", done, 0);
        end else begin
          done_t d;
          d = done_q.pop_front();
          if (d.cyc >= 0) chk("done_cycle", cyc, d.cyc);
`ifdef PRESENT_CORE_SCAN_FRAME_CNT_EN
          chk("frame_count_at_done", frame_count, d.cnt);
`else
          chk("frame_count_at_done", frame_count, 0);
`endif
        end
      end
      // An aborted frame leaves nothing further to expect.
      if (abort) beat_q.delete();
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_x     = bus.out_x;
      prev_y     = bus.out_y;
      prev_eol   = bus.out_eol;
      prev_eof   = bus.out_eof;
    end
  end

  // Issue a start pulse and push the row-major beats the frame should yield.
  task automatic start_frame(input int w, input int h, input bit complete, input bit timed);
    int c;
    logic [31:0] cw, ch;
    cw = {16'($urandom), w[15:0]};
    ch = {16'($urandom), h[15:0]};
    cfg_width  = cw;
    cfg_height = ch;
    start = 1'b1;
    c = cyc;
    if (w > 0 && h > 0) begin
      for (int yy = 0; yy < h; yy++) begin
        for (int xx = 0; xx < w; xx++) begin
          beat_t b;
          b.x   = xx;
          b.y   = yy;
          b.eol = (xx == w - 1);
          b.eof = (xx == w - 1) && (yy == h - 1);
          b.cyc = timed ? c + 1 + yy * w + xx : -1;
          beat_q.push_back(b);
        end
      end
    end
    if (complete) begin
      done_t d;
      d.cnt = model_frames;
      if (w == 0 || h == 0) d.cyc = c + 1;
      else d.cyc = timed ? c + 1 + w * h : -1;
      done_q.push_back(d);
      model_frames++;
    end
    step();
    start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((beat_q.size() != 0 || done_q.size() != 0) && n < 3000) begin
      step();
      n++;
    end
    if (n >= 3000) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: timeout with %0d beats and %0d dones outstanding, required 0",
               name, beat_q.size(), done_q.size());
    end
    step();
  endtask

  function automatic int exp_count();
`ifdef PRESENT_CORE_SCAN_FRAME_CNT_EN
    return model_frames;
`else
    return 0;
`endif
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, n;
    // Reset state.
    step();
    step();
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_x", bus.out_x, 0);
    chk("rst_eol", bus.out_eol, 0);
    chk("rst_frame_count", frame_count, 0);
    reset_n = 1'b1;
    step();

    // 4x3 at full throughput, timed.
    start_frame(4, 3, 1'b1, 1'b1);
    wait_idle("frame_4x3");

    // 3x2 with random backpressure.
    rand_ready = 1'b1;
    start_frame(3, 2, 1'b1, 1'b0);
    wait_idle("frame_3x2_stall");
    rand_ready = 1'b0;
    step();

    // Zero-sized frames: done only.
    start_frame(0, 5, 1'b1, 1'b1);
    wait_idle("frame_0x5");
    start_frame(5, 0, 1'b1, 1'b1);
    wait_idle("frame_5x0");

    // 8x8 aborted on the 10th beat, then a full rescan.
    base = beats_seen;
    start_frame(8, 8, 1'b0, 1'b1);
    n = 0;
    while (beats_seen - base < 9 && n < 200) begin
      step();
      n++;
    end
    chk("abort_reach_beat9", beats_seen - base, 9);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_valid", bus.out_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_frame_count", frame_count, exp_count());
    step();
    start_frame(8, 8, 1'b1, 1'b1);
    wait_idle("frame_8x8_rescan");

    // Start and height change mid-scan are ignored.
    start_frame(4, 5, 1'b1, 1'b1);
    repeat (6) step();
    cfg_height = 32'd9;
    start = 1'b1;
    step();
    start = 1'b0;
    wait_idle("frame_4x5_ignore_start");

    // Three single-pixel frames.
    for (int i = 0; i < 3; i++) begin
      start_frame(1, 1, 1'b1, 1'b1);
      wait_idle("frame_1x1");
    end
    chk("frame_count_after_1x1", frame_count, exp_count());

    // Random frames with random backpressure.
    rand_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      int w, h;
      w = $urandom_range(0, 6);
      h = $urandom_range(0, 5);
      start_frame(w, h, 1'b1, 1'b0);
      wait_idle("frame_random");
    end
    rand_ready = 1'b0;
    step();
    chk("frame_count_after_random", frame_count, exp_count());

    // Asynchronous reset in the middle of a frame.
    start_frame(6, 6, 1'b0, 1'b1);
    repeat (5) step();
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_valid", bus.out_valid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_x", bus.out_x, 0);
    chk("arst_y", bus.out_y, 0);
    chk("arst_eol", bus.out_eol, 0);
    chk("arst_eof", bus.out_eof, 0);
    chk("arst_frame_count", frame_count, 0);
    model_frames = 0;
    step();
    reset_n = 1'b1;
    step();

    // Scanner is usable again after reset.
    start_frame(2, 3, 1'b1, 1'b1);
    wait_idle("frame_after_reset");
    chk("final_frame_count", frame_count, exp_count());
    chk("final_beat_q_empty", beat_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
